// File: rtl/uart_rx_int_ctrl_if.sv
// CPU-side and serial-line signals of the UART receiver. The receiver
// connects to the slave modport; the CPU/bench connects to the master modport.
interface uart_rx_int_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          uart_in;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic [CW-1:0] fifo_cnt;
  logic          int0;
  logic          ovr_err;
  logic          frm_err;

  modport slave (
    input  uart_in, rd_en, clr_err,
    output rd_data, fifo_cnt, int0, ovr_err, frm_err
  );

  modport master (
    output uart_in, rd_en, clr_err,
    input  rd_data, fifo_cnt, int0, ovr_err, frm_err
  );
endinterface

// File: rtl/uart_rx_int_ctrl.sv
// 8N1 UART receiver with a show-ahead receive FIFO, sticky error flags and a
// level interrupt for the CPU.
module uart_rx_int_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_int_ctrl_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  logic [1:0]    sync_q;
  logic          sin_prev_q;
  logic          sin;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    sh_q, sh_d;
  logic          push, frm_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ovr_q, ovr_d, frm_q, frm_d, int0_q, int0_d;
  logic          full, pop, wr_en, ovr_set;

  assign sin = sync_q[1];

  // Synchronizer idles high so a reset never looks like a start edge by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      sin_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], bus.uart_in};
      sin_prev_q <= sin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      nbit_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      nbit_q  <= nbit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    nbit_d  = nbit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    frm_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        nbit_d = '0;
        if (sin_prev_q && !sin) state_d = S_START;
      end
      S_START: begin
        if (bcnt_q == HALF_M1) begin
          bcnt_d  = '0;
          state_d = sin ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d = '0;
          sh_d   = {sin, sh_q[7:1]};
          nbit_d = nbit_q + 1'b1;
          if (nbit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d = '0;
          if (sin) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frm_set = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) parks here so it flags only once.
        bcnt_d = '0;
        if (sin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full     = (fcnt_q == CW'(FIFO_DEPTH));
    pop      = bus.rd_en && (fcnt_q != '0);
    wr_en    = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fcnt_d   = fcnt_q;
    case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    // Next head is the incoming byte when it lands in the slot the read pointer moves to.
    rd_data_d = rd_data_q;
    if (fcnt_d != '0)
      rd_data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? sh_q : mem_q[rd_ptr_d];
    ovr_d  = (ovr_q & ~bus.clr_err) | ovr_set;
    frm_d  = (frm_q & ~bus.clr_err) | frm_set;
    int0_d = (fcnt_q != '0) | ovr_q | frm_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sh_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      rd_data_q <= 8'h00;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      int0_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      rd_data_q <= rd_data_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      int0_q    <= int0_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.fifo_cnt = fcnt_q;
  assign bus.int0     = int0_q;
  assign bus.ovr_err  = ovr_q;
  assign bus.frm_err  = frm_q;
endmodule

// File: doc/uart_rx_int_ctrl.md
UART_RX_INT_CTRL -- requirements
Module: uart_rx_int_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; SHALL be an even value >= 8.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; SHALL be a power of two.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; SHALL take effect immediately when low, independent of clk.
REQ-005 uart_in  input  1  asynchronous serial receive line; idle high; 8N1 framing, LSB first.
REQ-006 rd_en  input  1  CPU pop strobe, one cycle per byte.
REQ-007 clr_err  input  1  one-cycle pulse that clears the sticky error flags.
REQ-008 rd_data  output  8  FIFO head byte, show-ahead.
REQ-009 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-010 int0  output  1  level interrupt to mips_cpu int0.
REQ-011 ovr_err  output  1  sticky overrun flag.
REQ-012 frm_err  output  1  sticky framing-error flag.

Function
REQ-013 uart_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (sin).
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: a 1-to-0 transition on sin SHALL move the FSM to START and clear the bit-period counter.
REQ-016 START: at counter = CLKS_PER_BIT/2-1, sin=0 SHALL move the FSM to DATA with the counter cleared; sin=1 SHALL be treated as a false start and return the FSM to IDLE with no flag set.
REQ-017 DATA: at each counter = CLKS_PER_BIT-1, sin SHALL be shifted into the shift register MSB-side so that the first bit lands in bit 0 after 8 samples; after the 8th sample the FSM SHALL move to STOP.
REQ-018 STOP: at counter = CLKS_PER_BIT-1, sin=1 SHALL push the byte and return the FSM to IDLE; sin=0 SHALL discard the byte, set frm_err and move the FSM to WAIT_HIGH.
REQ-019 WAIT_HIGH: the FSM SHALL stay in WAIT_HIGH until sin=1, then go to IDLE; a break condition (line held low) SHALL therefore set frm_err only once.
REQ-020 Push: the byte SHALL be written on the stop-sample edge; fifo_cnt SHALL increment on that same edge.
REQ-021 A push while the FIFO is full and rd_en is low SHALL drop the new byte, keep the FIFO contents unchanged and set ovr_err.
REQ-022 A push and rd_en in the same cycle with the FIFO full SHALL pop the head and write the new byte, leave fifo_cnt unchanged and leave ovr_err unchanged.
REQ-023 rd_en with the FIFO empty SHALL be ignored: no pointer change, no underflow, rd_data unchanged.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 rd_data SHALL equal the FIFO head whenever fifo_cnt>0, and SHALL hold its last value when the FIFO is empty.
REQ-026 int0 SHALL be registered and equal (fifo_cnt != 0) OR ovr_err OR frm_err as of the previous cycle, so it rises 1 cycle after the push edge.
REQ-027 clr_err SHALL clear ovr_err and frm_err on the next edge; if clr_err coincides with a new error event, the flag SHALL end up set.
REQ-028 Latency from the uart_in falling edge to the push SHALL be 9.5*CLKS_PER_BIT cycles, +2..+3 cycles of synchronizer delay.

Reset
REQ-029 When rst is low: FSM = IDLE; counters, pointers and shift register = 0; rd_data = 8'h00; fifo_cnt = 0; int0 = 0; ovr_err = 0; frm_err = 0; synchronizer flops = 1.
REQ-030 A reset asserted mid-frame SHALL abandon the frame without pushing it; after release the FSM SHALL require a fresh falling edge on sin.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-031 Send 0xA5 as 8N1 at 16 clk/bit -> push within 152..155 cycles of the start edge; int0=1 one cycle later; rd_data=0xA5; fifo_cnt=1; after rd_en pulse, fifo_cnt=0 and int0=0 the next cycle.
REQ-032 Pull uart_in low for 5 cycles, then return it high -> false start; FSM back in IDLE; fifo_cnt=0; frm_err=0; int0=0.
REQ-033 Send 0x3C with the stop bit = 0 -> frm_err=1, fifo_cnt=0, int0=1; hold the line low 100 cycles -> frm_err is set only once; clr_err -> frm_err=0 and int0=0.
REQ-034 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> fifo_cnt=4 and ovr_err=1; successive reads return 0x01..0x04.
REQ-035 With the FIFO full, assert rd_en on the stop-sample edge of a 5th byte 0x55 -> ovr_err=0, fifo_cnt=4, and the last entry read out is 0x55.
REQ-036 Assert rst low during DATA of byte 0xFF, then release it, then send 0x12 -> only 0x12 is received and fifo_cnt=1.
